pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline: drives enable/bubble of PC, IF/ID, ID/EX, EX/MEM regs.

---
 rtl/pipe_ctrl_pkg.sv | 77 +++++++
 rtl/hazard_detect.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  localparam int unsigned RegAwDefault = 4;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StHalted,
    StError
  } ctrl_state_t;

  // Pipeline-register control fields; a bubble zeroes every one of them.
  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic mem_to_reg;
    logic mem_read;
    logic branch;
    logic jump;
  } ctrl_fields_t;

  localparam ctrl_fields_t BubbleFields = '0;

  typedef struct packed {
    logic pc_enable;
    logic if_id_enable;
    logic if_id_flush;
    logic id_ex_enable;
    logic id_ex_bubble;
    logic ex_mem_enable;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CtrlFreeze = '0;

  localparam pipe_ctrl_t CtrlFlow = '{
    pc_enable:     1'b1,
    if_id_enable:  1'b1,
    if_id_flush:   1'b0,
    id_ex_enable:  1'b1,
    id_ex_bubble:  1'b0,
    ex_mem_enable: 1'b1
  };

  // PC takes the branch target while the two wrong-path instructions are squashed.
  localparam pipe_ctrl_t CtrlBranch = '{
    pc_enable:     1'b1,
    if_id_enable:  1'b1,
    if_id_flush:   1'b1,
    id_ex_enable:  1'b1,
    id_ex_bubble:  1'b1,
    ex_mem_enable: 1'b1
  };

  localparam pipe_ctrl_t CtrlLoadUse = '{
    pc_enable:     1'b0,
    if_id_enable:  1'b0,
    if_id_flush:   1'b0,
    id_ex_enable:  1'b1,
    id_ex_bubble:  1'b1,
    ex_mem_enable: 1'b1
  };

  localparam pipe_ctrl_t CtrlDrain = '{
    pc_enable:     1'b0,
    if_id_enable:  1'b1,
    if_id_flush:   1'b1,
    id_ex_enable:  1'b1,
    id_ex_bubble:  1'b0,
    ex_mem_enable: 1'b1
  };

  function automatic logic state_active(input ctrl_state_t st);
    return (st == StRun) || (st == StDrain);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use compare between the instruction in ID and a load in EX.
module hazard_detect #(
  parameter int unsigned REG_AW = 4
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  output logic              load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
  assign load_use = ex_mem_to_reg && ex_reg_write && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/drain sequencer for the 5-stage pipeline.
// Optional PIPE_STALL_CNT_EN adds a saturating stall_cycles counter output.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW      = RegAwDefault,
  parameter int unsigned MAX_WAIT    = 255,
  parameter int unsigned DRAIN_DEPTH = 3,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              halt_req,
  output logic              pc_enable,
  output logic              if_id_enable,
  output logic              if_id_flush,
  output logic              id_ex_enable,
  output logic              id_ex_bubble,
  output logic              ex_mem_enable,
  output logic              halt_ack,
  output logic              mem_timeout
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles
`endif
);

  localparam int unsigned WaitW  = $clog2(MAX_WAIT + 1);
  localparam int unsigned DrainW = $clog2(DRAIN_DEPTH + 1);

  if (MAX_WAIT == 0 || DRAIN_DEPTH == 0 || CNT_W == 0) begin : gen_param_check
    $error("pipeline_hazard_ctrl: MAX_WAIT, DRAIN_DEPTH and CNT_W must be >= 1");
  end

  ctrl_state_t       state_q;
  logic [WaitW-1:0]  wait_cnt_q;
  logic [DrainW-1:0] drain_cnt_q;
  logic              halt_ack_q;
  logic              mem_timeout_q;

  logic       active;
  logic       mem_stall;
  logic       load_use;
  logic       wait_at_max;
  logic       drain_done;
  pipe_ctrl_t ctrl;

  hazard_detect #(
    .REG_AW(REG_AW)
  ) u_hazard_detect (
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg),
    .load_use     (load_use)
  );

  assign active      = state_active(state_q);
  assign mem_stall   = active && mem_req && !mem_ready;
  assign wait_at_max = (wait_cnt_q == WaitW'(MAX_WAIT - 1));
  assign drain_done  = (drain_cnt_q == DrainW'(DRAIN_DEPTH - 1));

  // A stalled branch stays in EX, so it is simply re-applied once memory completes.
  always_comb begin
    ctrl = CtrlFreeze;
    if (active) begin
      if (mem_stall) begin
        ctrl = CtrlFreeze;
      end else if (ex_branch_taken) begin
        ctrl = CtrlBranch;
      end else if (load_use) begin
        ctrl = CtrlLoadUse;
      end else if (state_q == StDrain) begin
        ctrl = CtrlDrain;
      end else begin
        ctrl = CtrlFlow;
      end
    end
  end

  assign pc_enable     = ctrl.pc_enable;
  assign if_id_enable  = ctrl.if_id_enable;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_enable  = ctrl.id_ex_enable;
  assign id_ex_bubble  = ctrl.id_ex_bubble;
  assign ex_mem_enable = ctrl.ex_mem_enable;
  assign halt_ack      = halt_ack_q;
  assign mem_timeout   = mem_timeout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StRun;
      wait_cnt_q    <= '0;
      drain_cnt_q   <= '0;
      halt_ack_q    <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        StRun, StDrain: begin
          if (mem_stall) begin
            wait_cnt_q <= wait_cnt_q + WaitW'(1);
            if (wait_at_max) begin
              state_q       <= StError;
              mem_timeout_q <= 1'b1;
            end else if (state_q == StRun && halt_req) begin
              state_q     <= StDrain;
              drain_cnt_q <= '0;
            end
          end else begin
            wait_cnt_q <= '0;
            if (state_q == StRun) begin
              if (halt_req) begin
                state_q     <= StDrain;
                drain_cnt_q <= '0;
              end
            end else if (drain_done) begin
              // A halt_req dropped mid-drain still completes via HALTED.
              state_q    <= StHalted;
              halt_ack_q <= 1'b1;
            end else begin
              drain_cnt_q <= drain_cnt_q + DrainW'(1);
            end
          end
        end
        StHalted: begin
          wait_cnt_q <= '0;
          if (!halt_req) begin
            state_q    <= StRun;
            halt_ack_q <= 1'b0;
          end
        end
        StError: begin
          state_q <= StError;
        end
        default: begin
          state_q <= StRun;
        end
      endcase
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
    end else if (active && !ctrl.pc_enable && (stall_cycles_q != '1)) begin
      stall_cycles_q <= stall_cycles_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: stimulus queues expectations, monitor checks them.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned REG_AW = 4;
  localparam int unsigned CNT_W  = 16;

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en}
  localparam logic [5:0] FLOW = 6'b110101;
  localparam logic [5:0] FRZ  = 6'b000000;
  localparam logic [5:0] BRN  = 6'b111111;
  localparam logic [5:0] LDU  = 6'b000111;
  localparam logic [5:0] DRN  = 6'b011101;

  typedef struct {
    string      name;
    logic [5:0] ctrl;
    logic       ack;
    logic       tmo;
    int         cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic              clk = 1'b0;
  logic              reset;
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
  logic              id_use_rs1, id_use_rs2, ex_reg_write, ex_mem_to_reg;
  logic              ex_branch_taken, mem_req, mem_ready, halt_req;
  logic              pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_bubble;
  logic              ex_mem_enable, halt_ack, mem_timeout;
  logic [5:0]        act;
`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0]  stall_cycles;
`endif

  always #5 clk = ~clk;

  assign act = {pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_bubble, ex_mem_enable};

  pipeline_hazard_ctrl #(
    .REG_AW     (REG_AW),
    .MAX_WAIT   (8),
    .DRAIN_DEPTH(3),
    .CNT_W      (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .ex_rd          (ex_rd),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_to_reg  (ex_mem_to_reg),
    .ex_branch_taken(ex_branch_taken),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .halt_req       (halt_req),
    .pc_enable      (pc_enable),
    .if_id_enable   (if_id_enable),
    .if_id_flush    (if_id_flush),
    .id_ex_enable   (id_ex_enable),
    .id_ex_bubble   (id_ex_bubble),
    .ex_mem_enable  (ex_mem_enable),
    .halt_ack       (halt_ack),
    .mem_timeout    (mem_timeout)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_reg_write = 0; ex_mem_to_reg = 0;
    ex_branch_taken = 0; mem_req = 0; mem_ready = 0; halt_req = 0;
  endtask

  task automatic expect_cyc(input string nm, input logic [5:0] c, input logic a,
                            input logic t, input int n = -1);
    exp_t e;
    e.name = nm; e.ctrl = c; e.ack = a; e.tmo = t; e.cnt = n;
    sb_q.push_back(e);
  endtask

  task automatic set_load(input logic [REG_AW-1:0] rd);
    ex_rd = rd; ex_reg_write = 1; ex_mem_to_reg = 1;
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (act !== e.ctrl) begin
          errors++;
          $display("FAIL %s ctrl got %b want %b", e.name, act, e.ctrl);
        end
        checks++;
        if (halt_ack !== e.ack) begin
          errors++;
          $display("FAIL %s halt_ack got %b want %b", e.name, halt_ack, e.ack);
        end
        checks++;
        if (mem_timeout !== e.tmo) begin
          errors++;
          $display("FAIL %s mem_timeout got %b want %b", e.name, mem_timeout, e.tmo);
        end
`ifdef PIPE_STALL_CNT_EN
        if (e.cnt >= 0) begin
          checks++;
          if (int'(stall_cycles) != e.cnt) begin
            errors++;
            $display("FAIL %s stall_cycles got %0d want %0d", e.name, stall_cycles, e.cnt);
          end
        end
`endif
      end
    end
  end

  initial begin
    reset = 1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    expect_cyc("reset", FLOW, 0, 0, 0);

    // Load-use detection and its negative cases
    tick(); set_load(3); id_rs1 = 3; id_use_rs1 = 1;
    expect_cyc("lu_rs1", LDU, 0, 0);
    tick(); ex_reg_write = 0; ex_mem_to_reg = 0; ex_rd = 0;
    expect_cyc("lu_resolved", FLOW, 0, 0, 1);
    tick(); set_load(5); id_use_rs1 = 0; id_rs2 = 5; id_use_rs2 = 1;
    expect_cyc("lu_rs2", LDU, 0, 0);
    tick(); id_use_rs2 = 0;
    expect_cyc("no_use", FLOW, 0, 0);
    tick(); set_load(4); id_rs1 = 3; id_use_rs1 = 1;
    expect_cyc("rd_diff", FLOW, 0, 0);
    tick(); ex_rd = 3; ex_reg_write = 0;
    expect_cyc("no_wr", FLOW, 0, 0);
    tick(); ex_reg_write = 1; ex_mem_to_reg = 0;
    expect_cyc("alu_dep", FLOW, 0, 0);

    // Memory wait with a taken branch held in EX
    for (int i = 0; i < 4; i++) begin
      tick(); idle(); mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
      expect_cyc("memwait_br", FRZ, 0, 0);
    end
    tick(); mem_ready = 1;
    expect_cyc("br_after_wait", BRN, 0, 0);
    tick(); idle();
    expect_cyc("post_br", FLOW, 0, 0);
    tick(); set_load(2); id_rs1 = 2; id_use_rs1 = 1; ex_branch_taken = 1;
    expect_cyc("br_over_lu", BRN, 0, 0);
    tick(); idle();
    expect_cyc("post_br2", FLOW, 0, 0);

    // Memory timeout: 8 stalled cycles then ERROR
    for (int i = 0; i < 8; i++) begin
      tick(); mem_req = 1; mem_ready = 0;
      expect_cyc("wait_pre_tmo", FRZ, 0, 0);
    end
    tick();
    expect_cyc("error", FRZ, 0, 1);
    for (int i = 0; i < 2; i++) begin
      tick(); idle();
      expect_cyc("error_hold", FRZ, 0, 1);
    end
    tick(); reset = 1;
    tick(); reset = 0;
    expect_cyc("rst_from_err", FLOW, 0, 0);

    // Halt with a 2-cycle memory stall inside the drain
    tick(); halt_req = 1;
    expect_cyc("halt_req", FLOW, 0, 0);
    tick();
    expect_cyc("drain0", DRN, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick(); mem_req = 1; mem_ready = 0;
      expect_cyc("drain_stall", FRZ, 0, 0);
    end
    tick(); mem_req = 0;
    expect_cyc("drain1", DRN, 0, 0);
    tick();
    expect_cyc("drain2", DRN, 0, 0);
    tick();
    expect_cyc("halted", FRZ, 1, 0);
    tick();
    expect_cyc("halted_hold", FRZ, 1, 0);
    tick(); halt_req = 0;
    expect_cyc("halt_release", FRZ, 1, 0);
    tick();
    expect_cyc("resumed", FLOW, 0, 0);

    // halt_req dropped mid-drain: drain still completes through HALTED
    tick(); halt_req = 1;
    expect_cyc("halt_req2", FLOW, 0, 0);
    tick(); halt_req = 0;
    expect_cyc("drop_drain0", DRN, 0, 0);
    tick();
    expect_cyc("drop_drain1", DRN, 0, 0);
    tick();
    expect_cyc("drop_drain2", DRN, 0, 0);
    tick();
    expect_cyc("drop_halted", FRZ, 1, 0);
    tick();
    expect_cyc("drop_resumed", FLOW, 0, 0);

    // Reset mid-drain, then a full drain to prove the drain counter restarted
    tick(); halt_req = 1;
    expect_cyc("halt_req3", FLOW, 0, 0);
    tick();
    expect_cyc("rd_drain0", DRN, 0, 0);
    tick();
    expect_cyc("rd_drain1", DRN, 0, 0);
    tick(); reset = 1; halt_req = 0;
    tick(); reset = 0;
    expect_cyc("rst_mid_drain", FLOW, 0, 0, 0);
    tick(); halt_req = 1;
    expect_cyc("halt_req4", FLOW, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_cyc("full_drain", DRN, 0, 0);
    end
    tick();
    expect_cyc("halted2", FRZ, 1, 0);
    tick(); halt_req = 0;
    expect_cyc("halt_release2", FRZ, 1, 0);
    tick();
    expect_cyc("resumed2", FLOW, 0, 0);

    repeat (2) tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending %0d want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
